// File: rtl/io_sequencer.sv
// io_sequencer: board I/O handshake between the CPU and the switch/button/display hardware.
// - On an input request it stalls the CPU (Halt) and shows the live switch value.
// - It waits for a debounced press of Swap, captures DataIO and returns it with a
//   one-cycle InValid strobe.
// - On an output request it latches CpuData for the display while the CPU is not halted.
// Optional build macro IO_TIMEOUT_EN: aborts a press wait after TIMEOUT_CYCLES,
// returns 0 and raises the sticky TimedOut flag.
module io_sequencer #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [31:0] TIMEOUT_CYCLES  = 32'd500000000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        InReq,
    input  logic        OutReq,
    input  logic [31:0] CpuData,
    input  logic [31:0] DataIO,
    input  logic        Swap,
    input  logic        Type,
    output logic        Halt,
    output logic [31:0] InData,
    output logic        InValid,
    output logic [31:0] DispValue,
    output logic        DispType,
    output logic        TimedOut
);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        WAIT_RELEASE = 3'd1,
        WAIT_PRESS   = 3'd2,
        CAPTURE      = 3'd3,
        DONE         = 3'd4
    } state_t;

    state_t      state_reg, state_next;
    logic        halt_reg, halt_next;
    logic        in_valid_reg, in_valid_next;
    logic [31:0] in_data_reg, in_data_next;
    logic        timed_out_reg, timed_out_next;

    logic        sync1_reg, sync2_reg;
    logic [15:0] db_cnt_reg;
    logic        sw_db_reg;
    logic        press_reg;
    logic        db_hit;

    logic [31:0] out_reg;
    logic [31:0] disp_reg;
    logic        disp_type_reg;

    logic        to_hit;
    logic        capture_timeout;

    // Two-flop synchronizer for the asynchronous pushbutton
    always_ff @(posedge Clock) begin
        if (Reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= Swap;
            sync2_reg <= sync1_reg;
        end
    end

    assign db_hit = (db_cnt_reg == (DEBOUNCE_CYCLES - 16'd1));

    // Debounce: level must disagree with sw_db for DEBOUNCE_CYCLES cycles before it flips;
    // press_reg pulses for one cycle together with the first high cycle of sw_db
    always_ff @(posedge Clock) begin
        if (Reset) begin
            db_cnt_reg <= 16'd0;
            sw_db_reg  <= 1'b0;
            press_reg  <= 1'b0;
        end else if (sync2_reg == sw_db_reg) begin
            db_cnt_reg <= 16'd0;
            press_reg  <= 1'b0;
        end else if (db_hit) begin
            db_cnt_reg <= 16'd0;
            sw_db_reg  <= ~sw_db_reg;
            press_reg  <= ~sw_db_reg;
        end else begin
            db_cnt_reg <= db_cnt_reg + 16'd1;
            press_reg  <= 1'b0;
        end
    end

`ifdef IO_TIMEOUT_EN
    logic [31:0] to_cnt_reg;

    assign to_hit = (to_cnt_reg == (TIMEOUT_CYCLES - 32'd1));

    // Press-wait timer: zero outside WAIT_PRESS, counts up inside it and parks at the limit
    always_ff @(posedge Clock) begin
        if (Reset) begin
            to_cnt_reg <= 32'd0;
        end else if (state_reg != WAIT_PRESS) begin
            to_cnt_reg <= 32'd0;
        end else if (!to_hit) begin
            to_cnt_reg <= to_cnt_reg + 32'd1;
        end
    end
`else
    // No timer in this build: the press wait never expires (parameter kept for a common interface)
    assign to_hit = (TIMEOUT_CYCLES == 32'd0) & 1'b0;
`endif

    // A timeout only counts when no press arrives in the same cycle
    assign capture_timeout = (state_reg == WAIT_PRESS) && InReq && !press_reg && to_hit;

    // FSM state and registered handshake outputs
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg     <= IDLE;
            halt_reg      <= 1'b0;
            in_valid_reg  <= 1'b0;
            in_data_reg   <= 32'd0;
            timed_out_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            halt_reg      <= halt_next;
            in_valid_reg  <= in_valid_next;
            in_data_reg   <= in_data_next;
            timed_out_reg <= timed_out_next;
        end
    end

    // Next-state logic; a dropped InReq abandons the wait, a held one never recaptures
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (InReq) state_next = WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                if (!InReq)         state_next = IDLE;
                else if (!sw_db_reg) state_next = WAIT_PRESS;
            end
            WAIT_PRESS: begin
                if (!InReq)         state_next = IDLE;
                else if (press_reg) state_next = CAPTURE;
                else if (to_hit)    state_next = CAPTURE;
            end
            CAPTURE: begin
                state_next = DONE;
            end
            DONE: begin
                if (!InReq) state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output decode from the next state so Halt, InValid and InData line up with the state
    always_comb begin
        halt_next      = (state_next == WAIT_RELEASE) || (state_next == WAIT_PRESS);
        in_valid_next  = (state_next == CAPTURE);
        in_data_next   = in_data_reg;
        timed_out_next = timed_out_reg;
        if (state_next == CAPTURE) begin
            in_data_next   = capture_timeout ? 32'd0 : DataIO;
            timed_out_next = capture_timeout;
        end
    end

    // Output-instruction latch and display path (live switches while halted)
    always_ff @(posedge Clock) begin
        if (Reset) begin
            out_reg       <= 32'd0;
            disp_reg      <= 32'd0;
            disp_type_reg <= 1'b0;
        end else begin
            if (OutReq) out_reg <= CpuData;
            disp_reg      <= halt_reg ? DataIO : out_reg;
            disp_type_reg <= Type;
        end
    end

    assign Halt      = halt_reg;
    assign InValid   = in_valid_reg;
    assign InData    = in_data_reg;
    assign DispValue = disp_reg;
    assign DispType  = disp_type_reg;
    assign TimedOut  = timed_out_reg;

endmodule

// File: doc/io_sequencer.md
Name: io_sequencer

Overview:
Sequences the board I/O path between the processor and the switch/button/display hardware. On a CPU input request it stalls the CPU with Halt and shows the live switch value. It waits for a debounced press of the Swap button, captures DataIO, hands the value to the CPU and releases the stall. On a CPU output request it latches the written word as the value the display interface shows while the CPU is not halted.

Parameters:
DEBOUNCE_CYCLES, 16'd50000, cycles a synchronized Swap level must stay stable before the debounced level changes (range 1..65535).
TIMEOUT_CYCLES, 32'd500000000, cycles allowed in WAIT_PRESS before abort (used only with IO_TIMEOUT_EN).

Ports:
Clock  input  1  system clock; all logic on the rising edge.
Reset  input  1  synchronous, active-high reset.
InReq  input  1  CPU executing an input instruction; level, held until the CPU sees InValid.
OutReq  input  1  CPU executing an output instruction; single-cycle strobe.
CpuData  input  32  value written by the output instruction.
DataIO  input  32  switch bank value.
Swap  input  1  raw, asynchronous confirm pushbutton (active-high).
Type  input  1  display format select; passed through registered.
Halt  output  1  CPU stall request.
InData  output  32  captured input word to the CPU.
InValid  output  1  one-cycle strobe: InData is valid.
DispValue  output  32  word for the display interface.
DispType  output  1  registered Type.
TimedOut  output  1  sticky abort flag (held at 0 without IO_TIMEOUT_EN).

Behaviour:
- Reset (sync, Reset=1 at a rising edge) sets the following, with priority over every other event:
  - state=IDLE; Halt=0, InValid=0, TimedOut=0.
  - InData=0, the output register OutReg=0, DispType=0.
  - Synchronizer flops, debounce counter and debounced level sw_db all 0.
- Reset mid-handshake aborts it; no InValid is produced.
- Swap conditioning:
  - Two-flop synchronizer.
  - Counter clears whenever the synchronized level equals sw_db; otherwise it increments.
  - When the count reaches DEBOUNCE_CYCLES-1, sw_db toggles and the counter clears.
  - Press edge = sw_db rising, registered (one cycle).
- OutReq:
  - When OutReq=1, in any non-reset state, OutReg<=CpuData on that edge.
  - Independent of the FSM, so it is legal simultaneously with InReq.
- FSM, with Halt as a registered output:
  - IDLE, Halt=0: InReq=1 -> WAIT_RELEASE; Halt=1 from the next cycle.
  - WAIT_RELEASE, Halt=1: sw_db=0 -> WAIT_PRESS. A button already held when InReq arrives is never accepted as confirmation.
  - WAIT_PRESS, Halt=1: press edge -> CAPTURE.
  - CAPTURE, 1 cycle: InData<=DataIO as sampled this cycle; InValid=1; Halt=0 from the next cycle; -> DONE.
  - DONE, Halt=0: InReq=0 -> IDLE. A held InReq never retriggers a second capture.
- Latency:
  - InReq to Halt high: 1 cycle.
  - Press edge to InValid: 1 cycle.
  - InValid and the Halt fall occur on the same edge.
- InValid is high only in the CAPTURE cycle. InData holds its value until the next capture or reset.
- InReq dropping during WAIT_RELEASE or WAIT_PRESS: return to IDLE, Halt<=0, no InValid.
- DispValue, registered:
  - DataIO when Halt=1.
  - OutReg when Halt=0.
  - Updates one cycle after its source changes.
- DispType<=Type every cycle.
- All arithmetic is unsigned. The counters saturate, never wrap: the debounce counter clears on match, and the timeout counter stops at its limit.

Optional Feature:
Macro IO_TIMEOUT_EN.
- Defined:
  - A 32-bit counter clears on entry to WAIT_PRESS and increments each cycle spent there.
  - At TIMEOUT_CYCLES-1 the FSM goes to CAPTURE with InData<=0 (not DataIO) and sets TimedOut=1.
  - TimedOut stays sticky until reset or the next successful press capture, which clears it.
  - A press edge and the timeout in the same cycle: the press wins, DataIO is captured and TimedOut is not set.
- Not defined: no counter is built, TimedOut is tied to 0, and WAIT_PRESS waits indefinitely.

Test Plan:
- Reset check: with DEBOUNCE_CYCLES=4, hold Reset 2 cycles while InReq=1 and Swap=1 -> Halt=0, InValid=0, InData=0, DispValue=0, state IDLE.
- Normal input: InReq=1, DataIO=32'h0000_00A5; Swap held high for 10 cycles, then low -> Halt=1 one cycle after InReq; then InValid pulses exactly once with InData=32'hA5, Halt falls on the same edge, and DispValue showed 32'hA5 while halted.
- Held button: Swap already debounced high when InReq rises -> no capture until Swap is released and pressed again; exactly one InValid.
- Bounce: Swap toggling every 2 cycles for 20 cycles (DEBOUNCE_CYCLES=4) -> no press edge, Halt stays 1; then a stable press -> one capture.
- Output path plus simultaneity: OutReq=1 with CpuData=32'h1234_5678 in the same cycle InReq rises -> OutReg=32'h12345678; DispValue=DataIO during the halt and returns to 32'h12345678 one cycle after Halt falls.
- Timeout (IO_TIMEOUT_EN, TIMEOUT_CYCLES=20): InReq with no press -> InValid after about 20 cycles in WAIT_PRESS with InData=0 and TimedOut=1; a later normal capture clears TimedOut.
